// File: rtl/alu64_seq_ctrl.sv
// alu64_seq_ctrl: sequencing controller around one shared 64-bit
// carry-lookahead adder. Runs single-cycle ADD/SUB and a 32-step radix-2
// Booth signed multiply that reuses the same adder every cycle.

// 64-bit carry-lookahead adder with carry-out and signed overflow.
module cla64_ov (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        ci_i,
  output logic [63:0] s_o,
  output logic        co_o,
  output logic        ovf_o
);

  logic [63:0] g;
  logic [63:0] p;
  logic [64:0] c;
  logic        grp_g;
  logic        grp_p;

  // 4-bit lookahead blocks; each block's carry-out comes from its group G/P.
  always_comb begin
    g     = a_i & b_i;
    p     = a_i ^ b_i;
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    c[0]  = ci_i;
    for (int unsigned blk = 0; blk < 16; blk++) begin
      c[4*blk+1] = g[4*blk] | (p[4*blk] & c[4*blk]);
      c[4*blk+2] = g[4*blk+1] | (p[4*blk+1] & g[4*blk])
                 | (p[4*blk+1] & p[4*blk] & c[4*blk]);
      c[4*blk+3] = g[4*blk+2] | (p[4*blk+2] & g[4*blk+1])
                 | (p[4*blk+2] & p[4*blk+1] & g[4*blk])
                 | (p[4*blk+2] & p[4*blk+1] & p[4*blk] & c[4*blk]);
      grp_g = g[4*blk+3] | (p[4*blk+3] & g[4*blk+2])
            | (p[4*blk+3] & p[4*blk+2] & g[4*blk+1])
            | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & g[4*blk]);
      grp_p = p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & p[4*blk];
      c[4*blk+4] = grp_g | (grp_p & c[4*blk]);
    end
    s_o   = p ^ c[63:0];
    co_o  = c[64];
    ovf_o = c[64] ^ c[63];
  end

endmodule

module alu64_seq_ctrl #(
  parameter int WIDTH    = 64,
  parameter int MUL_BITS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             co
);

  localparam int CW = $clog2(MUL_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_BITS - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [MUL_BITS:0]   acc_q, acc_d;
  logic [MUL_BITS-1:0] mq_q, mq_d;
  logic                qm1_q, qm1_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                co_q, co_d;

  logic [WIDTH-1:0]    add_x, add_y, add_s;
  logic                add_ci, add_co, add_ovf;
  logic [1:0]          booth;
  logic [MUL_BITS:0]   acc_new;
  logic [WIDTH-1:0]    m_ext;

  cla64_ov u_add (
    .a_i   (add_x),
    .b_i   (add_y),
    .ci_i  (add_ci),
    .s_o   (add_s),
    .co_o  (add_co),
    .ovf_o (add_ovf)
  );

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      co_q     <= co_d;
    end
  end

  // Next-state, adder operand steering and Booth step.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    co_d     = co_q;
    add_x    = '0;
    add_y    = '0;
    add_ci   = 1'b0;
    booth    = {mq_q[0], qm1_q};
    acc_new  = acc_q;
    m_ext    = {{(WIDTH-MUL_BITS){a_q[MUL_BITS-1]}}, a_q[MUL_BITS-1:0]};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          if (op == OP_MUL) begin
            acc_d   = '0;
            mq_d    = b[MUL_BITS-1:0];
            qm1_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        add_x  = a_q;
        add_y  = (op_q == OP_SUB) ? ~b_q : b_q;
        add_ci = (op_q == OP_SUB);
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          result_d = add_s;
          co_d     = add_co;
          ovf_d    = add_ovf;
        end else begin
          result_d = '0;
          co_d     = 1'b0;
          ovf_d    = 1'b0;
        end
        state_d = S_DONE;
      end

      S_MUL: begin
        // A is 33 bits wide and sign-extended into the adder so A-M stays
        // exact even for M = -2^31; only the low 33 sum bits are kept.
        if (booth == 2'b01 || booth == 2'b10) begin
          add_x   = {{(WIDTH-MUL_BITS-1){acc_q[MUL_BITS]}}, acc_q};
          add_y   = (booth == 2'b10) ? ~m_ext : m_ext;
          add_ci  = (booth == 2'b10);
          acc_new = add_s[MUL_BITS:0];
        end
        acc_d = {acc_new[MUL_BITS], acc_new[MUL_BITS:1]};
        mq_d  = {acc_new[0], mq_q[MUL_BITS-1:1]};
        qm1_d = mq_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = {acc_d[MUL_BITS-1:0], mq_d};
          ovf_d    = 1'b0;
          co_d     = 1'b0;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign ovf    = ovf_q;
  assign co     = co_q;

endmodule

// File: tb/tb_alu64_seq_ctrl.sv
// Self-checking bench for alu64_seq_ctrl: random and directed commands
// checked every cycle against a behavioural arithmetic model.
module tb_alu64_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy, done, ovf, co;
  logic [63:0] result;

  int total = 0;
  int bad = 0;

  alu64_seq_ctrl #(.WIDTH(64), .MUL_BITS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf),
    .co      (co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic meaning of each command, independent of any hardware structure.
  function automatic void ref_calc(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                                   output logic [63:0] r, output logic v, output logic c);
    logic [64:0] t;
    longint      prod;
    r = '0; v = 1'b0; c = 1'b0;
    case (o)
      2'b00: begin
        t = {1'b0, x} + {1'b0, y};
        r = t[63:0];
        c = t[64];
        v = (x[63] == y[63]) && (r[63] != x[63]);
      end
      2'b01: begin
        r = x - y;
        c = (x >= y);
        v = (x[63] != y[63]) && (r[63] != x[63]);
      end
      2'b10: begin
        prod = longint'($signed(x[31:0])) * longint'($signed(y[31:0]));
        r = prod;
      end
      default: ;
    endcase
  endfunction

  // Model: rem = busy cycles left; done when rem==1; results land then.
  int          rem = 0;
  logic [63:0] m_res = '0, p_res = '0;
  logic        m_ovf = 1'b0, m_co = 1'b0, p_ovf = 1'b0, p_co = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem = 0; m_res = '0; m_ovf = 1'b0; m_co = 1'b0;
    end else if (rem == 0) begin
      if (start) begin
        ref_calc(op, a, b, p_res, p_ovf, p_co);
        rem = (op == 2'b10) ? 33 : 2;
      end
    end else begin
      rem--;
      if (rem == 1) begin
        m_res = p_res; m_ovf = p_ovf; m_co = p_co;
      end
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    chk("busy", busy, rem > 0);
    chk("done", done, rem == 1);
    chk("result", result, m_res);
    chk("ovf", ovf, m_ovf);
    chk("co", co, m_co);
  end

  task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                     input bit lit, input logic [63:0] er, input logic ev, input logic ec);
    int cyc;
    issue(o, x, y);
    wait_done(cyc);
    chk("latency", 64'(cyc), (o == 2'b10) ? 64'd32 : 64'd1);
    if (lit) begin
      chk("lit_result", result, er);
      chk("lit_ovf", ovf, ev);
      chk("lit_co", co, ec);
    end
  endtask

  logic [63:0] corner [8] = '{64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF,
                              64'h8000000000000000, 64'h0000000080000000,
                              64'h000000007FFFFFFF, 64'hFFFFFFFF80000000};

  initial begin
    logic [63:0] r, rx, ry;
    logic        v, c;
    int          cyc;

    // Pin the model with hand-computed values.
    ref_calc(2'b00, 64'h7FFFFFFFFFFFFFFF, 64'd1, r, v, c);
    chk("model_add", {r[62:0], v}, {63'h0, 1'b1});
    chk("model_add_msb", {63'h0, r[63]}, 64'd1);
    ref_calc(2'b01, 64'd5, 64'd5, r, v, c);
    chk("model_sub_co", {r[62:0], c}, 64'd1);
    ref_calc(2'b10, 64'hFFFFFFFD, 64'd7, r, v, c);
    chk("model_mul", r, 64'hFFFFFFFFFFFFFFEB);

    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 64'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run(2'b00, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b1, 64'h8000000000000000, 1'b1, 1'b0);
    run(2'b01, 64'd0, 64'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    run(2'b01, 64'd5, 64'd5, 1'b1, 64'h0, 1'b0, 1'b1);
    run(2'b10, 64'h12345678FFFFFFFD, 64'hABCDEF0100000007, 1'b1, 64'hFFFFFFFFFFFFFFEB, 1'b0, 1'b0);
    run(2'b10, 64'h80000000, 64'h80000000, 1'b1, 64'h4000000000000000, 1'b0, 1'b0);
    run(2'b10, 64'h7FFFFFFF, 64'hFFFFFFFF, 1'b1, 64'hFFFFFFFF80000001, 1'b0, 1'b0);
    run(2'b11, 64'd9, 64'd9, 1'b1, 64'h0, 1'b0, 1'b0);

    // start during MUL is ignored.
    issue(2'b10, 64'd1000, 64'hFFFFFFFE);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 64'd1; b = 64'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("ign_latency", 64'(cyc + 9), 64'd32);
    chk("ign_result", result, 64'hFFFFFFFFFFFFF830);
    repeat (3) @(negedge clk);
    chk("ign_hold", result, 64'hFFFFFFFFFFFFF830);

    // Reset in the middle of a multiply.
    issue(2'b10, 64'd123, 64'd456);
    repeat (14) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_result", result, 64'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    run(2'b00, 64'd2, 64'd3, 1'b1, 64'd5, 1'b0, 1'b0);

    // Randomized commands, mixing corner operands.
    for (int i = 0; i < 60; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : {$urandom, $urandom};
      ry = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : {$urandom, $urandom};
      run(2'($urandom), rx, ry, 1'b0, '0, 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu64_seq_ctrl.md
Name: alu64_seq_ctrl

Overview:
Sequencing controller for one shared 64-bit carry-lookahead adder with overflow detection (cla64_ov, instanced internally).
- Executes single-cycle ADD/SUB.
- Executes a 32-iteration radix-2 Booth signed multiply (32x32 -> 64) by reusing the same adder every cycle.
- Sits between the top-level operand/command registers and the result bus.
- Start/done handshake; result held until the next accepted command.

Parameters:
WIDTH, 64, datapath width; fixed to match the adder.
MUL_BITS, 32, Booth operand width and iteration count.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  command request; sampled only in IDLE
op  input  2  00=ADD, 01=SUB, 10=MUL, 11=illegal
a  input  64  operand A (MUL uses a[31:0] as signed multiplicand M)
b  input  64  operand B (MUL uses b[31:0] as signed multiplier Q)
busy  output  1  high in EXEC, MUL, DONE
done  output  1  one-cycle pulse; result/flags valid
result  output  64  registered result
ovf  output  1  signed overflow (ADD/SUB); 0 for MUL/illegal
co  output  1  adder carry-out (ADD/SUB); 0 for MUL/illegal

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, result=0, ovf=0, co=0; internal A/Q/q_m1/count/op registers cleared. Applies immediately, including mid-operation; the in-flight command is discarded.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - start=1 at edge k: latch op, a, b.
  - op=00/01/11 -> EXEC. op=10 -> MUL with A=0 (33 bits), Q=b[31:0], q_m1=0, count=0.
- EXEC, one cycle:
  - ADD: adder(a, b, ci=0). SUB: adder(a, ~b, ci=1).
  - At edge k+1: result=s, co=co, ovf=co^co_prev, done=1 -> DONE.
  - Illegal op: result=0, ovf=0, co=0, same timing.
- MUL, one Booth step per cycle:
  - {Q[0],q_m1}=01: A=A+M. 10: A=A-M (adder with ~M, ci=1). 00/11: A unchanged (adder idle).
  - Adder operands are 64-bit sign-extended A and M; low 33 bits kept, so the M=-2^31 case is exact.
  - Then arithmetic shift right of {A,Q,q_m1} by 1. count++.
  - At edge k+32 (count reaches 31 -> step done): result={A[31:0],Q}, ovf=0, co=0, done=1 -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE with done=0. result/ovf/co hold until overwritten by the next command.
- start while busy=1 (EXEC/MUL/DONE) is ignored, not queued. Earliest new accept is the first IDLE cycle after DONE.
- Changes to a/b/op after acceptance have no effect.
- Latency, start edge to done high: ADD/SUB/illegal = 1 cycle; MUL = 32 cycles. Throughput: one command per N+2 cycles.

Test Plan:
- ADD a=0x7FFFFFFFFFFFFFFF, b=1 -> result=0x8000000000000000, ovf=1, co=0, done 1 cycle after start, busy for 2 cycles.
- SUB a=0, b=1 -> result=0xFFFFFFFFFFFFFFFF, ovf=0, co=0; SUB a=5, b=5 -> result=0, co=1, ovf=0.
- MUL a[31:0]=0xFFFFFFFD (-3), b[31:0]=7 -> result=0xFFFFFFFFFFFFFFEB after exactly 32 cycles; ovf=0; done pulse width 1.
- MUL 0x80000000 x 0x80000000 -> result=0x4000000000000000; MUL 0x7FFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFF80000001.
- start pulsed with op=ADD during MUL cycle 10 -> ignored; MUL result correct; result unchanged until a later accepted start.
- reset_n low at MUL cycle 15 -> busy=0, done=0, result=0 immediately; after release, a fresh ADD 2+3 -> result=5 with normal 1-cycle latency.
